env_adsr: RTL
=============

# env_adsr

ADSR envelope generator sitting directly upstream of the synth voice: it turns a gate level (button or sequencer) into the 10-bit amplitude word driving the voice's `amp_in`. The envelope is time-stepped by an internal prescaler derived from the system clock (48 MHz HFOSC), so attack, decay and release rates are set by parameters. Sustain level is a live input.

## Interface
- `CLKSPEED`, default 48_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 48_000: envelope step rate. `TICK_DIV = CLKSPEED/TICK_HZ`, which must be ≥ 2.
- `ATTACK_STEP`, default 1: amplitude added per tick in ATTACK. Legal range 1..1023.
- `DECAY_STEP`, default 1: amplitude subtracted per tick in DECAY. Legal range 1..1023.
- `RELEASE_STEP`, default 1: amplitude subtracted per tick in RELEASE. Legal range 1..1023.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-high.
- `gate` in 1: note gate. Asynchronous level.
- `sustain_in` in 10: sustain amplitude, 0..1023.
- `amp_out` out 10: envelope amplitude. Registered.
- `state_out` out 3: current state. IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active` out 1: high whenever state ≠ IDLE. Registered.
- `tick_out` out 1: one-cycle step strobe. Exported for debug and LED use.

## Operation
- **Reset values.** While `rst` is high, all of the following are 0: `amp_out`, `state_out` (IDLE), `active`, `tick_out`, both synchronizer flops, and the prescaler.
- **Gate synchronizer.** `gate` passes through two flops to become `gate_s`. Every pulse that is captured propagates; there is no debounce.
- **Prescaler.** Free-running counter from 0 to TICK_DIV-1.
  - `tick` is high for the single cycle in which the counter equals TICK_DIV-1.
  - The counter runs independently of state.
- **State changes on level, evaluated every cycle (not only on tick):**
  - IDLE or RELEASE with `gate_s`=1 → ATTACK. Amplitude is kept, so a retrigger starts from the current level.
  - ATTACK, DECAY or SUSTAIN with `gate_s`=0 → RELEASE. Amplitude is kept.
- **Amplitude updates, only on tick cycles.** All arithmetic is 11-bit unsigned with saturation.
  - **ATTACK:** `amp` = min(`amp` + ATTACK_STEP, 1023). If the result is 1023, the state moves to DECAY on the same edge.
  - **DECAY:** if `amp` ≤ `sustain_in` + DECAY_STEP, then `amp` = `sustain_in` and the state moves to SUSTAIN. Otherwise `amp` -= DECAY_STEP.
  - **SUSTAIN:** `amp` = `sustain_in` on every cycle, not only on ticks, so live sustain edits take effect immediately.
  - **RELEASE:** if `amp` ≤ RELEASE_STEP, then `amp` = 0 and the state moves to IDLE. Otherwise `amp` -= RELEASE_STEP.
  - **IDLE:** `amp` is held at 0.
- **Priority.** A gate-driven transition wins over a tick-driven one in the same cycle. On that edge the amplitude is not stepped.
  - Example: a tick in ATTACK with `gate_s`=0 gives RELEASE with `amp` unchanged.
- **Decay while `sustain_in` changes.** The comparison uses the current `sustain_in` value.
  - If `sustain_in` ≥ `amp` at a DECAY tick, `amp` = `sustain_in` and the state moves to SUSTAIN. This can raise `amp`, which is allowed.
- **Short gate pulses.** A one-cycle `gate` pulse gives one cycle of ATTACK, then RELEASE.
  - If `amp` is 0, the next tick returns the block to IDLE.

## Timing
- **Gate latency.** If `gate` changes before edge k, `gate_s` changes at edge k+1 and `state_out` changes at edge k+2.
- **Step visibility.** An amplitude step computed on a tick cycle is visible on `amp_out` after that edge, i.e. in the cycle after `tick_out`.
- **First tick after reset.** The first `tick_out` is high in cycle TICK_DIV-1 after `rst` deasserts. Ticks then repeat every TICK_DIV cycles.
- **`active` alignment.** `active` is updated on the same edge as `state_out`.
- **Reset mid-envelope.** `amp_out` goes to 0 immediately (asynchronously) and no ramp occurs. After release of reset, the block starts in IDLE.

## Test plan
All scenarios use TICK_DIV=4, ATTACK_STEP=256, DECAY_STEP=128, RELEASE_STEP=100 and `sustain_in`=512.

1. **Full attack and decay.** Raise `gate` and hold it.
   - Expected on successive ticks: `amp_out` = 256, 512, 768, 1023 (saturated), with the state going to DECAY on the 1023 step.
   - Then 895, 767, 639, then 512 with state SUSTAIN.
2. **Release from sustain.** Drop `gate` from SUSTAIN.
   - Expected: RELEASE within 3 cycles, with `amp` unchanged at the transition.
   - Then on ticks: 412, 312, 212, 112, 12, then 0 with IDLE and `active`=0.
3. **Retrigger in release.** Re-raise `gate` while `amp` is 312 in RELEASE.
   - Expected: ATTACK from 312, then 568, 824, 1023, then DECAY.
4. **Live sustain change.** In SUSTAIN, change `sustain_in` from 512 to 300.
   - Expected: `amp_out` = 300 one cycle later, with no tick required.
   - Set `sustain_in`=1023 during DECAY. Expected: the next tick gives `amp` 1023 and SUSTAIN.
5. **Reset mid-attack.** Assert `rst` asynchronously at `amp` 512.
   - Expected: `amp_out`=0, `state_out`=0 and `active`=0 before the next clock edge.
6. **One-cycle gate pulse from IDLE.**
   - Expected: ATTACK for one cycle, then RELEASE.
   - If no tick falls in the ATTACK cycle: `amp` stays 0 and the next tick returns to IDLE.
   - If a tick does fall in the ATTACK cycle: `amp` = 256, and it decays to 0 (IDLE) after 3 ticks.

Source files
------------

// File: rtl/env_adsr.sv
// ADSR envelope generator: turns a gate level into a 10-bit amplitude word.
// The amplitude is stepped on a prescaled tick; state changes follow the gate every cycle.
module env_adsr #(
    parameter int CLKSPEED     = 48_000_000,
    parameter int TICK_HZ      = 48_000,
    parameter int ATTACK_STEP  = 1,
    parameter int DECAY_STEP   = 1,
    parameter int RELEASE_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [9:0] sustain_in,
    output logic [9:0] amp_out,
    output logic [2:0] state_out,
    output logic       active,
    output logic       tick_out
);

    localparam int TICK_DIV = CLKSPEED / TICK_HZ;
    localparam int CW       = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [10:0]   AMP_MAX  = 11'd1023;
    localparam logic [10:0]   A_STEP   = 11'(ATTACK_STEP);
    localparam logic [10:0]   D_STEP   = 11'(DECAY_STEP);
    localparam logic [10:0]   R_STEP   = 11'(RELEASE_STEP);
    localparam logic [9:0]    D_STEP10 = 10'(DECAY_STEP);
    localparam logic [9:0]    R_STEP10 = 10'(RELEASE_STEP);

    // Encoding is exported on state_out: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    amp_q, amp_d;
    logic          active_q;
    logic          sync1_q, gate_s_q;
    logic [CW-1:0] cnt_q;
    logic          tick;

    logic [10:0]   amp_ext;
    logic [10:0]   atk_sum;
    logic [10:0]   decay_floor;

    assign tick        = (cnt_q == CNT_MAX);
    assign amp_ext     = {1'b0, amp_q};
    assign atk_sum     = amp_ext + A_STEP;
    assign decay_floor = {1'b0, sustain_in} + D_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            gate_s_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            amp_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sync1_q  <= gate;
            gate_s_q <= sync1_q;
            cnt_q    <= tick ? '0 : cnt_q + CW'(1);
            state_q  <= state_d;
            amp_q    <= amp_d;
            active_q <= (state_d != S_IDLE);
        end
    end

    // Gate-driven transitions are tested first so they pre-empt any tick step.
    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        case (state_q)
            S_IDLE: begin
                amp_d = '0;
                if (gate_s_q) state_d = S_ATTACK;
            end
            S_ATTACK: begin
                if (!gate_s_q) begin
                    state_d = S_RELEASE;
                end else if (tick) begin
                    if (atk_sum >= AMP_MAX) begin
                        amp_d   = 10'd1023;
                        state_d = S_DECAY;
                    end else begin
                        amp_d = atk_sum[9:0];
                    end
                end
            end
            S_DECAY: begin
                if (!gate_s_q) begin
                    state_d = S_RELEASE;
                end else if (tick) begin
                    if (amp_ext <= decay_floor) begin
                        amp_d   = sustain_in;
                        state_d = S_SUSTAIN;
                    end else begin
                        amp_d = amp_q - D_STEP10;
                    end
                end
            end
            S_SUSTAIN: begin
                if (!gate_s_q) state_d = S_RELEASE;
                else           amp_d   = sustain_in;
            end
            S_RELEASE: begin
                if (gate_s_q) begin
                    state_d = S_ATTACK;
                end else if (tick) begin
                    if (amp_ext <= R_STEP) begin
                        amp_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        amp_d = amp_q - R_STEP10;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                amp_d   = '0;
            end
        endcase
    end

    assign amp_out   = amp_q;
    assign state_out = state_q;
    assign active    = active_q;
    assign tick_out  = tick;

endmodule
